// File: rtl/xport_arb_if.sv
// xport_arb_if -- handshake bundle between requester FIFOs, the arbiter
// and the downstream sink.
//   slave  : arbiter side (consumes FIFO heads, produces output beats)
//   master : environment side (FIFOs and downstream sink)
interface xport_arb_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = $clog2(N);

    // Requester FIFO side (show-ahead heads)
    logic [N-1:0]    req_empty_n;
    logic [N*DW-1:0] req_dout;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_re;

    // Downstream beat stream
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;

    // Status
    logic [IW-1:0]   grant_id;
    logic            busy;

    modport slave (
        input  req_empty_n, req_dout, req_last, out_ready,
        output req_re, out_valid, out_data, out_last, grant_id, busy
    );

    modport master (
        output req_empty_n, req_dout, req_last, out_ready,
        input  req_re, out_valid, out_data, out_last, grant_id, busy
    );
endinterface

// File: rtl/xport_arb.sv
// xport_arb -- round-robin arbiter merging N show-ahead FIFOs into one
// valid/ready beat stream with a single registered output stage.
//
// Optional feature macro: XARB_PKT_LOCK_EN
//   defined   : a grant is held until the beat carrying req_last has been
//               popped, so packets are never interleaved.
//   undefined : every grant moves exactly one beat; req_last is only
//               forwarded to out_last.
//
// One IDLE cycle is spent on every arbitration; pops happen only in XFER.
module xport_arb #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rstn,
    xport_arb_if.slave  bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   grant_reg, grant_next;
    logic [IW-1:0]   last_grant_reg, last_grant_next;
    logic            out_valid_reg, out_valid_next;
    logic [DW-1:0]   out_data_reg, out_data_next;
    logic            out_last_reg, out_last_next;

    // Rotated candidate list: entry k is requester (last_grant + k + 1) mod N
    logic [IW-1:0]   cand_idx [N];
    logic [N-1:0]    cand_hit;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    // Granted FIFO head, selected by the current grant
    logic [DW-1:0]   dout_slice [N];
    logic [DW-1:0]   head_data;
    logic            head_last;
    logic            can_accept;
    logic [N-1:0]    req_re_c;
    logic            pop;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            logic [IW:0] cand_sum;

            // Offset from the last grant; the sum stays below 2N so a
            // single conditional subtract performs the modulo.
            assign cand_sum     = {1'b0, last_grant_reg} + (IW+1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum >= (IW+1)'(N)) ?
                                  IW'(cand_sum - (IW+1)'(N)) : IW'(cand_sum);
            assign cand_hit[gi] = bus.req_empty_n[cand_idx[gi]];

            assign dout_slice[gi] = bus.req_dout[gi*DW +: DW];

            // Pop only the granted FIFO, only when it has a head and the
            // output register is free or being emptied this cycle.
            assign req_re_c[gi] = (state_reg == XFER) &&
                                  (grant_reg == IW'(gi)) &&
                                  bus.req_empty_n[gi] &&
                                  can_accept;
        end
    endgenerate

    assign head_data  = dout_slice[grant_reg];
    assign head_last  = bus.req_last[grant_reg];
    assign can_accept = ~out_valid_reg | bus.out_ready;
    assign pop        = |req_re_c;

    // Pick the nearest non-empty candidate after the last grant
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, leave XFER on the closing pop
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next      = XFER;
                    grant_next      = pick_idx;
                    last_grant_next = pick_idx;
                end
            end
            XFER: begin
                if (pop) begin
`ifdef XARB_PKT_LOCK_EN
                    if (head_last) begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: load on pop, drain on accept, otherwise hold
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        if (pop) begin
            out_valid_next = 1'b1;
            out_data_next  = head_data;
            out_last_next  = head_last;
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // State and output registers; reset drops any held beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IW'(N - 1);
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
        end
    end

    assign bus.req_re    = req_re_c;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.grant_id  = grant_reg;
    assign bus.busy      = (state_reg == XFER);

endmodule

// File: tb/tb_xport_arb.sv
// tb_xport_arb -- randomized bench for xport_arb.
// FIFO contents live in queues; a packet-level round-robin model turns the
// preloaded contents into the expected grant order and beat stream, which
// a monitor compares against the DUT together with handshake invariants.
module tb_xport_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    typedef logic [DW:0] beat_t;   // {last, data}

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xport_arb_if #(.N(N), .DW(DW)) bus ();

    xport_arb #(.N(N), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    beat_t fq [N][$];     // live FIFO contents
    beat_t mq [N][$];     // model scratch copy
    beat_t exp_q [$];     // expected beat stream
    int    exp_g [$];     // expected grant order

    int       n_chk = 0;
    int       n_fail = 0;
    int       model_last = N - 1;
    int       seq = 0;
    bit       sb_en = 1'b0;
    bit       busy_prev = 1'b0;
    bit       hold_pend = 1'b0;
    beat_t    hold_beat;
    logic [N-1:0] pops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input int f, input int len);
        for (int b = 0; b < len; b++) begin
            fq[f].push_back({(b == len - 1) ? 1'b1 : 1'b0, 2'(f), 6'(seq)});
            seq++;
        end
    endtask

    // Round-robin over non-empty FIFOs, one packet (or one beat) per grant
    task automatic build_expect();
        int    sel;
        bit    found;
        beat_t b;
        for (int i = 0; i < N; i++) mq[i] = fq[i];
        forever begin
            found = 1'b0;
            sel   = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && mq[(model_last + k) % N].size() > 0) begin
                    found = 1'b1;
                    sel   = (model_last + k) % N;
                end
            end
            if (!found) break;
            model_last = sel;
            exp_g.push_back(sel);
`ifdef XARB_PKT_LOCK_EN
            do begin
                b = mq[sel].pop_front();
                exp_q.push_back(b);
            end while (!b[DW] && mq[sel].size() > 0);
`else
            b = mq[sel].pop_front();
            exp_q.push_back(b);
`endif
        end
    endtask

    task automatic drive_inputs(input logic [N-1:0] hmask);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() > 0) begin
                b = fq[i][0];
                bus.req_empty_n[i]        = ~hmask[i];
                bus.req_dout[i*DW +: DW]  = b[DW-1:0];
                bus.req_last[i]           = b[DW];
            end else begin
                bus.req_empty_n[i]        = 1'b0;
                bus.req_dout[i*DW +: DW]  = 8'($urandom);
                bus.req_last[i]           = 1'($urandom);
            end
        end
    endtask

    // Called at the falling edge, when all DUT outputs are settled
    task automatic monitor();
        chk("re_when_empty", 32'(bus.req_re & ~bus.req_empty_n), 0);
        chk("re_onehot", 32'($countones(bus.req_re) <= 1), 1);
        chk("re_in_idle", bus.busy ? 32'd0 : 32'(bus.req_re), 0);
        chk("re_in_stall", (bus.out_valid && !bus.out_ready) ? 32'(bus.req_re) : 32'd0, 0);
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_beat", 32'({bus.out_last, bus.out_data}), 32'(hold_beat));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_beat = {bus.out_last, bus.out_data};
        if (sb_en && bus.busy && !busy_prev) begin
            if (exp_g.size() == 0) chk("grant_extra", 1, 0);
            else chk("grant_id", 32'(bus.grant_id), 32'(exp_g.pop_front()));
        end
        busy_prev = bus.busy;
        if (sb_en && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("beat_extra", 1, 0);
            else chk("beat", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
        end
        pops = bus.req_re;
    endtask

    task automatic apply_pops();
        for (int i = 0; i < N; i++) begin
            if (pops[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
    endtask

    // mode 0: random ready + global hides, 1: ready low for 8 cycles,
    // 2: FIFO0 hidden on cycles 2..6, 3: ready always high
    task automatic run_scn(input string name, input int mode);
        int           cyc;
        logic [N-1:0] hmask;
        build_expect();
        sb_en = 1'b1;
        cyc   = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            hmask = '0;
            case (mode)
                0: begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 6) == 0) hmask = '1;
                end
                1: bus.out_ready = (cyc >= 8);
                2: begin
                    bus.out_ready = 1'b1;
                    if (cyc >= 2 && cyc <= 6) hmask = N'(1);
                end
                default: bus.out_ready = 1'b1;
            endcase
            drive_inputs(hmask);
            @(negedge clk);
            monitor();
`ifdef XARB_PKT_LOCK_EN
            if (mode == 2 && cyc >= 2 && cyc <= 6) begin
                chk("lock_busy", 32'(bus.busy), 1);
                chk("lock_grant", 32'(bus.grant_id), 0);
                chk("lock_re", 32'(bus.req_re), 0);
            end
`endif
            @(posedge clk);
            #1;
            apply_pops();
            cyc++;
        end
        chk("beats_done", 32'(exp_q.size()), 0);
        chk("grants_done", 32'(exp_g.size()), 0);
        $display("scenario %s: %0d cycles, %0d checks, %0d failures", name, cyc, n_chk, n_fail);
    endtask

    task automatic reset_mid();
        int cyc;
        sb_en = 1'b0;
        for (int i = 0; i < N; i++) fq[i].delete();
        add_pkt(1, 6);
        add_pkt(2, 1);
        bus.out_ready = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            drive_inputs('0);
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            apply_pops();
            cyc++;
        end
        chk("rst_pre_valid", 32'(bus.out_valid), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant_id), 0);
        chk("rst_req_re", 32'(bus.req_re), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) fq[i].delete();
        exp_q.delete();
        exp_g.delete();
        model_last = N - 1;
        busy_prev  = 1'b0;
        hold_pend  = 1'b0;
        drive_inputs('0);
        rstn = 1'b1;
        $display("scenario reset_mid: reset applied with out_valid held");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready   = 1'b0;
        bus.req_empty_n = '0;
        bus.req_dout    = '0;
        bus.req_last    = '0;
        rstn            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_grant", 32'(bus.grant_id), 0);
        chk("reset_req_re", 32'(bus.req_re), 0);
        chk("reset_out_data", 32'(bus.out_data), 0);
        chk("reset_out_last", 32'(bus.out_last), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // All requesters busy: grants must rotate 0,1,2,3,0,...
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) add_pkt(i, 1);
        run_scn("fair_rotation", 3);

        // Three-beat packet on FIFO1 competing with FIFO2
        add_pkt(1, 3);
        add_pkt(2, 2);
        run_scn("pkt_contig", 3);

        // Held beat 0xA5 under backpressure
        fq[2].push_back({1'b1, 8'hA5});
        fq[2].push_back({1'b1, 8'h3C});
        run_scn("backpressure", 1);

        // Non-last head on FIFO2 with FIFO3 waiting
        fq[2].push_back({1'b0, 8'h11});
        fq[2].push_back({1'b1, 8'h12});
        fq[3].push_back({1'b1, 8'h13});
        run_scn("last_zero_head", 3);

        // Reset mid-packet, then requester 0 must win first
        reset_mid();
        add_pkt(0, 3);
        add_pkt(3, 1);
        run_scn("granted_empty_wait", 2);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) add_pkt(i, $urandom_range(1, 4));
            end
            run_scn("random", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
